// File: rtl/shift_add_pkg.sv
// shift_add_pkg: shared types and sizing for the shift-add multiplier.
package shift_add_pkg;
   localparam int N_BITS = 4;
   localparam int ITERS = 4;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/shift_add_mult_adder.sv
// shift_add_mult_adder: 4-bit ripple-carry adder; sub feeds the carry chain as carry-in.
module shift_add_mult_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       sub,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;
   assign c[0] = sub;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i] = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[4];
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned multiplier, one shift-add iteration per RUN cycle.
module shift_add_mult #(
   parameter int N_BITS = shift_add_pkg::N_BITS
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic [N_BITS-1:0]   A,
   input  logic [N_BITS-1:0]   B,
   output logic                BUSY,
   output logic                DONE,
   output logic [2*N_BITS-1:0] P
);
   import shift_add_pkg::*;
   state_t state;
   logic [3:0] acc, q, m, add_sum, sum;
   logic [1:0] cnt;
   logic       add_c, c;
   logic [3:0] acc_n, q_n;
   shift_add_mult_adder u_add (
      .a   (acc),
      .b   (m),
      .sub (1'b0),
      .sum (add_sum),
      .cout(add_c)
   );
   assign {c, sum} = q[0] ? {add_c, add_sum} : {1'b0, acc};
   assign acc_n = {c, sum[3:1]};
   assign q_n = {sum[0], q[3:1]};
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         acc   <= '0;
         q     <= '0;
         m     <= '0;
         cnt   <= '0;
         P     <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  m     <= A;
                  q     <= B;
                  acc   <= '0;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= acc_n;
               q   <= q_n;
               cnt <= cnt + 2'd1;
               // Last iteration: publish the product in the same edge it completes
               if (cnt == 2'(ITERS - 1)) begin
                  P     <= {acc_n, q_n};
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               DONE  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
